// File: rtl/row_loader.sv
// Configuration sequencer for one 4-node row: unpacks a host word stream of
// per-node headers and instruction words into the row's prog/pLength/stack.
module row_loader #(
  parameter int NODES = 4,
  parameter int SLOTS = 15,
  parameter int WORD  = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [WORD-1:0] in_data,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [WORD-1:0] prog    [0:NODES*SLOTS-1],
  output logic [3:0]      pLength [0:NODES-1],
  output logic [NODES-1:0] stack,
  output logic            row_rst,
  output logic            busy,
  output logic            done,
  output logic            err
);

  localparam int NW = $clog2(NODES);
  localparam int PW = $clog2(NODES*SLOTS);

  typedef enum logic [2:0] {IDLE, HDR, BODY, RUN, ERR} state_t;

  state_t        state, state_d;
  logic [NW-1:0] node;
  logic [3:0]    slot;
  logic          xfer, hdr_ok, last_node, last_slot;
  logic [PW-1:0] wr_idx;
  logic          in_ready_d, busy_d, done_d, err_d, row_rst_d;

  // in_ready is decoded from the registered state, so it is exactly "in HDR or BODY".
  assign xfer      = in_valid && in_ready;
  assign hdr_ok    = (in_data[14:4] == '0);
  assign last_node = (node == NW'(NODES-1));
  assign last_slot = (slot == pLength[node] - 4'd1);
  assign wr_idx    = PW'(node) * PW'(SLOTS) + PW'(slot);

  // State register; the status flags are registered alongside it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      row_rst  <= 1'b1;
    end else begin
      state    <= state_d;
      in_ready <= in_ready_d;
      busy     <= busy_d;
      done     <= done_d;
      err      <= err_d;
      row_rst  <= row_rst_d;
    end
  end

  // Next-state logic; load restarts from any state and wins over a transfer.
  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    state_d = state;
    if (load) begin
      state_d = HDR;
    end else begin
      case (state)
        HDR: begin
          if (xfer) begin
            if (!hdr_ok)                state_d = ERR;
            else if (in_data[3:0] != '0) state_d = BODY;
            else if (last_node)         state_d = RUN;
            else                        state_d = HDR;
          end
        end
        BODY: begin
          if (xfer && last_slot) state_d = last_node ? RUN : HDR;
        end
        default: state_d = state;
      endcase
    end
  end

  // Flags are computed from the next state so they register in step with it.
  always_comb begin
    // NOTE: combinational blocks use blocking '='; clocked blocks use non-blocking '<='.
    in_ready_d = (state_d == HDR) || (state_d == BODY);
    busy_d     = (state_d == HDR) || (state_d == BODY);
    done_d     = (state_d == RUN);
    err_d      = (state_d == ERR);
    row_rst_d  = (state_d != RUN);
  end

  // Configuration datapath: cleared on reset or load, written only by transfers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the program store is reset on purpose; the row must see all-zero config while held.
      node  <= '0;
      slot  <= '0;
      stack <= '0;
      for (int n = 0; n < NODES; n++) pLength[n] <= '0;
      for (int i = 0; i < NODES*SLOTS; i++) prog[i] <= '0;
    end else if (load) begin
      node  <= '0;
      slot  <= '0;
      stack <= '0;
      for (int n = 0; n < NODES; n++) pLength[n] <= '0;
      for (int i = 0; i < NODES*SLOTS; i++) prog[i] <= '0;
    end else if (xfer && state == HDR && hdr_ok) begin
      stack[node]   <= in_data[15];
      pLength[node] <= in_data[3:0];
      slot          <= '0;
      if (in_data[3:0] == '0) node <= node + NW'(1);
    end else if (xfer && state == BODY) begin
      prog[wr_idx] <= in_data;
      if (last_slot) begin
        slot <= '0;
        node <= node + NW'(1);
      end else begin
        slot <= slot + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_row_loader.sv
// Directed self-checking bench for row_loader: full stream, gapped stream,
// malformed header, mid-load restart, empty nodes and asynchronous reset.
module tb_row_loader;

  logic        clk, rst, load, in_valid, in_ready;
  logic [15:0] in_data;
  logic [15:0] prog    [0:59];
  logic [3:0]  pLength [0:3];
  logic [3:0]  stack;
  logic        row_rst, busy, done, err;

  logic [15:0] exp_prog [0:59];
  logic [3:0]  exp_len  [0:3];
  logic [3:0]  exp_stack;
  logic [15:0] stream [$];

  int checks = 0;
  int errors = 0;

  row_loader dut (
    .clk(clk), .rst(rst), .load(load), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .prog(prog), .pLength(pLength), .stack(stack),
    .row_rst(row_rst), .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_flags(input string tag, input logic rdy, input logic bsy,
                             input logic dn, input logic er, input logic rr);
    check({tag, " in_ready"}, in_ready, rdy);
    check({tag, " busy"},     busy,     bsy);
    check({tag, " done"},     done,     dn);
    check({tag, " err"},      err,      er);
    check({tag, " row_rst"},  row_rst,  rr);
  endtask

  task automatic check_cfg(input string tag);
    for (int i = 0; i < 60; i++) check($sformatf("%s prog[%0d]", tag, i), prog[i], exp_prog[i]);
    for (int n = 0; n < 4; n++) check($sformatf("%s pLength[%0d]", tag, n), pLength[n], exp_len[n]);
    check({tag, " stack"}, stack, exp_stack);
  endtask

  task automatic clear_exp();
    for (int i = 0; i < 60; i++) exp_prog[i] = 16'h0;
    for (int n = 0; n < 4; n++) exp_len[n] = 4'h0;
    exp_stack = 4'b0000;
  endtask

  // Expected contents of the reference stream, written out by hand.
  task automatic set_stream_exp();
    clear_exp();
    exp_prog[0]  = 16'hAAAA;
    exp_prog[1]  = 16'hBBBB;
    for (int i = 0; i < 15; i++) exp_prog[30+i] = 16'h2000 + 16'(i);
    exp_prog[45] = 16'hCCCC;
    exp_len[0] = 4'd2; exp_len[1] = 4'd0; exp_len[2] = 4'd15; exp_len[3] = 4'd1;
    exp_stack = 4'b0100;
  endtask

  task automatic pulse_load();
    @(negedge clk); load = 1'b1;
    @(negedge clk); load = 1'b0;
  endtask

  // Offer one word after 'gap' idle cycles (random data on the bus while idle).
  task automatic send(input logic [15:0] w, input int gap);
    int n;
    repeat (gap) begin
      @(negedge clk); in_valid = 1'b0; in_data = 16'($urandom);
    end
    @(negedge clk); in_data = w; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk); n++;
    end
    check($sformatf("send_ready %04h", w), in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_data = 16'($urandom);
  endtask

  task automatic send_stream(input int max_gap);
    for (int i = 0; i < stream.size(); i++) begin
      if (i == stream.size() - 1) check("pre_last done", done, 1'b0);
      send(stream[i], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
    end
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; in_valid = 1'b0; in_data = 16'h0;
    stream = {16'h0002, 16'hAAAA, 16'hBBBB, 16'h0000, 16'h800F};
    for (int i = 0; i < 15; i++) stream.push_back(16'h2000 + 16'(i));
    stream.push_back(16'h0001);
    stream.push_back(16'hCCCC);

    // Reset, and words offered in IDLE are ignored
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    clear_exp();
    check_flags("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_cfg("reset");
    rst = 1'b1;
    in_valid = 1'b1; in_data = 16'h0003;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    check_flags("idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("idle pLength[0]", pLength[0], 4'd0);

    // Full stream, no gaps
    pulse_load();
    check_flags("load1", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    send_stream(0);
    check_flags("run1", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    set_stream_exp();
    check_cfg("stream");

    // Reload from RUN clears everything, then a gapped stream
    pulse_load();
    clear_exp();
    check_flags("load2", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    check_cfg("load2 clear");
    send_stream(5);
    check_flags("run2", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    set_stream_exp();
    check_cfg("gapped");

    // Malformed header for node 1
    pulse_load();
    send(16'h8001, 0);
    send(16'h1234, 0);
    send(16'h0010, 0);
    @(negedge clk);
    check_flags("err", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    in_valid = 1'b1; in_data = 16'h0001;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    check("err hold", err, 1'b1);
    check("err pLength[1]", pLength[1], 4'd0);
    check("err prog[15]", prog[15], 16'h0);
    check("err prog[0]", prog[0], 16'h1234);
    check("err stack", stack, 4'b0001);
    pulse_load();
    clear_exp();
    check_flags("err load", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    check_cfg("err clear");

    // Restart during node 2 BODY
    send(16'h0001, 0); send(16'h1111, 0);
    send(16'h0001, 0); send(16'h2222, 0);
    send(16'h0003, 0); send(16'h3333, 0);
    check("mid prog[30]", prog[30], 16'h3333);
    pulse_load();
    clear_exp();
    check_flags("mid load", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    check_cfg("mid clear");
    send_stream(0);
    check_flags("run3", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    set_stream_exp();
    check_cfg("restart");

    // Four empty nodes
    pulse_load();
    for (int n = 0; n < 4; n++) begin
      if (n == 3) check("empty pre done", done, 1'b0);
      send(16'h0000, 0);
    end
    check_flags("empty run", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    clear_exp();
    check_cfg("empty");

    // Asynchronous reset in the middle of BODY
    pulse_load();
    send(16'h0002, 0);
    send(16'hAAAA, 0);
    check("pre_rst prog[0]", prog[0], 16'hAAAA);
    #2 rst = 1'b0;
    #1;
    clear_exp();
    check_flags("async rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_cfg("async rst");
    @(negedge clk); rst = 1'b1;
    in_valid = 1'b1; in_data = 16'h0002;
    repeat (4) @(negedge clk);
    in_valid = 1'b0;
    check_flags("post rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("post rst pLength[0]", pLength[0], 4'd0);
    pulse_load();
    check_flags("post rst load", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
